// File: rtl/scalar_scoreboard_ctrl_pkg.sv
// Shared types and sizes for the scalar scoreboard: row state, row contents,
// register status entries and the FU index encoding.
package scalar_scoreboard_ctrl_pkg;

   localparam int NREG  = 32;
   localparam int NFU   = 3;
   localparam int TAG_W = 2;
   localparam int REG_W = 5;

   typedef enum logic [TAG_W-1:0] {
      FU_ALU    = 2'd0,
      FU_LD_ST  = 2'd1,
      FU_BRANCH = 2'd2
   } fu_scalar;

   typedef enum logic [1:0] {
      SB_FREE = 2'd0,
      SB_WAIT = 2'd1,
      SB_EXEC = 2'd2
   } sb_state_t;

   // One register status entry: pending write and which FU will produce it.
   typedef struct packed {
      logic             busy;
      logic [TAG_W-1:0] tag;
   } rst_s_row_t;

   // One FU status row.
   typedef struct packed {
      sb_state_t        state;
      logic             rd_en;
      logic [REG_W-1:0] rd;
      logic             rs1_en;
      logic [REG_W-1:0] rs1;
      logic             rs2_en;
      logic [REG_W-1:0] rs2;
      logic [TAG_W-1:0] t1;
      logic [TAG_W-1:0] t2;
      logic             r1;
      logic             r2;
   } sb_row_t;

   // A used register operand that is still waiting on a producer (x0 never waits).
   function automatic logic reg_pending(input logic en, input logic [REG_W-1:0] r,
                                        input rst_s_row_t e);
      return en && (r != '0) && e.busy;
   endfunction

endpackage

// File: rtl/scalar_scoreboard_ctrl_rr_arbiter.sv
// Round-robin arbiter: combinational one-hot grant, priority starts at a
// pointer that moves to just past the last winner.
module rr_arbiter #(
   parameter int N  = 3,
   parameter int IW = 2
) (
   input  logic          CLK,
   input  logic          nRST,
   input  logic [N-1:0]  req,
   output logic [N-1:0]  grant,
   output logic          grant_valid,
   output logic [IW-1:0] grant_idx
);

   logic [IW-1:0] ptr;
   logic [N-1:0]  req_hi;
   logic [N-1:0]  sel;

   // Prefer requesters at or above the pointer; otherwise wrap to the lowest one.
   always_comb begin
      req_hi      = '0;
      grant       = '0;
      grant_idx   = '0;
      grant_valid = |req;
      for (int k = 0; k < N; k++) begin
         req_hi[k] = req[k] && (IW'(k) >= ptr);
      end
      sel = (|req_hi) ? req_hi : req;
      for (int k = N - 1; k >= 0; k--) begin
         if (sel[k]) begin
            grant_idx = IW'(k);
         end
      end
      for (int k = 0; k < N; k++) begin
         grant[k] = grant_valid && (grant_idx == IW'(k));
      end
   end

   // Rotate priority to the requester after the winner.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         ptr <= '0;
      end else if (grant_valid) begin
         ptr <= (grant_idx == IW'(N - 1)) ? '0 : grant_idx + IW'(1);
      end
   end

endmodule

// File: rtl/scalar_scoreboard_ctrl.sv
// Scoreboard for the scalar FUs: register status table, per-FU status rows,
// dispatch hazard checks, operand wakeup and writeback-port arbitration.
module scalar_scoreboard_ctrl
   import scalar_scoreboard_ctrl_pkg::*;
(
   input  logic                   CLK,
   input  logic                   nRST,
   input  logic                   disp_valid,
   output logic                   disp_ready,
   input  logic [TAG_W-1:0]       disp_fu,
   input  logic                   disp_rd_en,
   input  logic                   disp_rs1_en,
   input  logic                   disp_rs2_en,
   input  logic [REG_W-1:0]       disp_rd,
   input  logic [REG_W-1:0]       disp_rs1,
   input  logic [REG_W-1:0]       disp_rs2,
   output logic [NFU-1:0]         issue_valid,
   input  logic [NFU-1:0]         issue_ack,
   output logic [NFU*REG_W-1:0]   issue_rd,
   output logic [NFU*REG_W-1:0]   issue_rs1,
   output logic [NFU*REG_W-1:0]   issue_rs2,
   input  logic [NFU-1:0]         wb_valid,
   output logic [NFU-1:0]         wb_ready,
   output logic                   rf_wen,
   output logic [REG_W-1:0]       rf_waddr,
   output logic [TAG_W-1:0]       rf_wsel
);

   sb_row_t    row_reg  [NFU];
   sb_row_t    row_next [NFU];
   rst_s_row_t rst_reg  [NREG];
   rst_s_row_t rst_next [NREG];

   logic [NFU-1:0]   elig;
   logic [NFU-1:0]   gnt;
   logic             gnt_valid;
   logic [TAG_W-1:0] gnt_idx;
   sb_row_t          g_row;

   logic row_free;
   logic accept;
   logic disp_r1;
   logic disp_r2;

   genvar gi;
   generate
      for (gi = 0; gi < NFU; gi++) begin : g_row_out
         logic war_hit;

         assign issue_valid[gi] = (row_reg[gi].state == SB_WAIT) && row_reg[gi].r1 && row_reg[gi].r2;
         assign issue_rd [gi*REG_W +: REG_W] = row_reg[gi].rd;
         assign issue_rs1[gi*REG_W +: REG_W] = row_reg[gi].rs1;
         assign issue_rs2[gi*REG_W +: REG_W] = row_reg[gi].rs2;

         // Hold this row's write while another waiting row still has to read the old value.
         // A row that writes nothing cannot clobber anything, so rd_en gates the check.
         always_comb begin
            war_hit = 1'b0;
            for (int j = 0; j < NFU; j++) begin
               if (j != gi && row_reg[j].state == SB_WAIT &&
                   row_reg[gi].rd_en && row_reg[gi].rd != '0 &&
                   ((row_reg[j].rs1_en && row_reg[j].r1 && row_reg[j].rs1 == row_reg[gi].rd) ||
                    (row_reg[j].rs2_en && row_reg[j].r2 && row_reg[j].rs2 == row_reg[gi].rd))) begin
                  war_hit = 1'b1;
               end
            end
         end

         assign elig[gi] = (row_reg[gi].state == SB_EXEC) && wb_valid[gi] && !war_hit;
      end
   endgenerate

   rr_arbiter #(
      .N  (NFU),
      .IW (TAG_W)
   ) u_wb_arb (
      .CLK         (CLK),
      .nRST        (nRST),
      .req         (elig),
      .grant       (gnt),
      .grant_valid (gnt_valid),
      .grant_idx   (gnt_idx)
   );

   assign g_row    = row_reg[gnt_idx];
   assign wb_ready = gnt;
   assign rf_wsel  = gnt_idx;
   assign rf_wen   = gnt_valid && g_row.rd_en && (g_row.rd != '0);
   assign rf_waddr = gnt_valid ? g_row.rd : '0;

   // Dispatch admission from registered state only; an out-of-range FU matches no row.
   always_comb begin
      row_free = 1'b0;
      for (int i = 0; i < NFU; i++) begin
         if (disp_fu == TAG_W'(i) && row_reg[i].state == SB_FREE) begin
            row_free = 1'b1;
         end
      end
   end

   assign disp_ready = row_free && !reg_pending(disp_rd_en, disp_rd, rst_reg[disp_rd]);
   assign accept     = disp_valid && disp_ready;

   // An operand whose producer is granted this very cycle is captured as ready.
   assign disp_r1 = !reg_pending(disp_rs1_en, disp_rs1, rst_reg[disp_rs1]) ||
                    (gnt_valid && gnt_idx == rst_reg[disp_rs1].tag);
   assign disp_r2 = !reg_pending(disp_rs2_en, disp_rs2, rst_reg[disp_rs2]) ||
                    (gnt_valid && gnt_idx == rst_reg[disp_rs2].tag);

   // Row FSMs, operand wakeup and register status updates.
   always_comb begin
      row_next = row_reg;
      rst_next = rst_reg;
      for (int i = 0; i < NFU; i++) begin
         case (row_reg[i].state)
            SB_FREE: begin
               if (accept && disp_fu == TAG_W'(i)) begin
                  row_next[i].state  = SB_WAIT;
                  row_next[i].rd_en  = disp_rd_en;
                  row_next[i].rd     = disp_rd;
                  row_next[i].rs1_en = disp_rs1_en;
                  row_next[i].rs1    = disp_rs1;
                  row_next[i].rs2_en = disp_rs2_en;
                  row_next[i].rs2    = disp_rs2;
                  row_next[i].t1     = rst_reg[disp_rs1].tag;
                  row_next[i].t2     = rst_reg[disp_rs2].tag;
                  row_next[i].r1     = disp_r1;
                  row_next[i].r2     = disp_r2;
               end
            end
            SB_WAIT: begin
               if (issue_valid[i] && issue_ack[i]) begin
                  row_next[i].state = SB_EXEC;
               end else begin
                  if (gnt_valid && !row_reg[i].r1 && row_reg[i].t1 == gnt_idx) begin
                     row_next[i].r1 = 1'b1;
                  end
                  if (gnt_valid && !row_reg[i].r2 && row_reg[i].t2 == gnt_idx) begin
                     row_next[i].r2 = 1'b1;
                  end
               end
            end
            SB_EXEC: begin
               if (gnt[i]) begin
                  row_next[i].state = SB_FREE;
               end
            end
            default: begin
               row_next[i].state = SB_FREE;
            end
         endcase
      end
      // Release the destination only if this FU is still its recorded producer.
      if (gnt_valid && g_row.rd_en && g_row.rd != '0 && rst_reg[g_row.rd].tag == gnt_idx) begin
         rst_next[g_row.rd].busy = 1'b0;
      end
      if (accept && disp_rd_en && disp_rd != '0) begin
         rst_next[disp_rd].busy = 1'b1;
         rst_next[disp_rd].tag  = disp_fu;
      end
   end

   // State registers; reset discards every in-flight instruction.
   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int i = 0; i < NFU; i++) begin
            row_reg[i] <= '0;
         end
         for (int r = 0; r < NREG; r++) begin
            rst_reg[r] <= '0;
         end
      end else begin
         row_reg <= row_next;
         rst_reg <= rst_next;
      end
   end

endmodule

// File: tb/tb_scalar_scoreboard_ctrl.sv
// Directed bench for scalar_scoreboard_ctrl: reset, dispatch/issue, RAW wakeup,
// WAW stall, round-robin order, WAR hold, same-cycle bypass, mid-flight reset.
module tb_scalar_scoreboard_ctrl;
   import scalar_scoreboard_ctrl_pkg::*;

   logic                 CLK = 1'b0;
   logic                 nRST;
   logic                 disp_valid;
   logic                 disp_ready;
   logic [TAG_W-1:0]     disp_fu;
   logic                 disp_rd_en, disp_rs1_en, disp_rs2_en;
   logic [REG_W-1:0]     disp_rd, disp_rs1, disp_rs2;
   logic [NFU-1:0]       issue_valid;
   logic [NFU-1:0]       issue_ack;
   logic [NFU*REG_W-1:0] issue_rd, issue_rs1, issue_rs2;
   logic [NFU-1:0]       wb_valid;
   logic [NFU-1:0]       wb_ready;
   logic                 rf_wen;
   logic [REG_W-1:0]     rf_waddr;
   logic [TAG_W-1:0]     rf_wsel;

   int n_total = 0;
   int n_pass  = 0;
   int n_fail  = 0;

   always #5 CLK = ~CLK;

   scalar_scoreboard_ctrl dut (
      .CLK         (CLK),
      .nRST        (nRST),
      .disp_valid  (disp_valid),
      .disp_ready  (disp_ready),
      .disp_fu     (disp_fu),
      .disp_rd_en  (disp_rd_en),
      .disp_rs1_en (disp_rs1_en),
      .disp_rs2_en (disp_rs2_en),
      .disp_rd     (disp_rd),
      .disp_rs1    (disp_rs1),
      .disp_rs2    (disp_rs2),
      .issue_valid (issue_valid),
      .issue_ack   (issue_ack),
      .issue_rd    (issue_rd),
      .issue_rs1   (issue_rs1),
      .issue_rs2   (issue_rs2),
      .wb_valid    (wb_valid),
      .wb_ready    (wb_ready),
      .rf_wen      (rf_wen),
      .rf_waddr    (rf_waddr),
      .rf_wsel     (rf_wsel)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   task automatic idle();
      disp_valid  = 1'b0;
      disp_fu     = '0;
      disp_rd_en  = 1'b0;
      disp_rs1_en = 1'b0;
      disp_rs2_en = 1'b0;
      disp_rd     = '0;
      disp_rs1    = '0;
      disp_rs2    = '0;
      issue_ack   = '0;
      wb_valid    = '0;
   endtask

   task automatic drive(input logic [1:0] fu, input logic rd_en, input logic [4:0] rd,
                        input logic e1, input logic [4:0] s1, input logic e2, input logic [4:0] s2);
      disp_valid  = 1'b1;
      disp_fu     = fu;
      disp_rd_en  = rd_en;
      disp_rd     = rd;
      disp_rs1_en = e1;
      disp_rs1    = s1;
      disp_rs2_en = e2;
      disp_rs2    = s2;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: bench did not reach its end");
      $fatal(1, "timeout");
   end

   initial begin
      // ---- reset ----
      idle();
      nRST = 1'b0;
      repeat (2) @(posedge CLK);
      #1;
      wb_valid = 3'b111;
      settle();
      check("rst_issue_valid", issue_valid, 0);
      check("rst_wb_ready", wb_ready, 0);
      check("rst_rf_wen", rf_wen, 0);
      wb_valid = '0;
      for (int f = 0; f < 3; f++) begin
         disp_fu = 2'(f); disp_rd_en = 1'b1; disp_rd = 5'd1;
         settle();
         check($sformatf("rst_ready_fu%0d", f), disp_ready, 1);
      end
      disp_fu = 2'd3;
      settle();
      check("bad_fu_ready", disp_ready, 0);
      idle();
      nRST = 1'b1;
      tick();

      // ---- ALU rd=3 rs1=1 rs2=2, all free ----
      idle(); drive(2'd0, 1, 5'd3, 1, 5'd1, 1, 5'd2);
      settle();
      check("t1_ready", disp_ready, 1);
      tick();
      idle(); settle();
      check("t1_issue_valid", issue_valid, 3'b001);
      check("t1_issue_rd", issue_rd[4:0], 3);
      check("t1_issue_rs1", issue_rs1[4:0], 1);
      check("t1_issue_rs2", issue_rs2[4:0], 2);
      disp_fu = 2'd1; disp_rd_en = 1'b1; disp_rd = 5'd3; settle();
      check("t1_rd3_busy", disp_ready, 0);
      disp_rd = 5'd9; settle();
      check("t1_rd9_free", disp_ready, 1);
      disp_fu = 2'd0; settle();
      check("t1_alu_row_busy", disp_ready, 0);
      idle(); issue_ack = 3'b001; tick();
      idle(); settle();
      check("t1_exec_no_issue", issue_valid, 0);
      wb_valid = 3'b001; settle();
      check("t1_wb_ready", wb_ready, 3'b001);
      check("t1_rf_wen", rf_wen, 1);
      check("t1_rf_waddr", rf_waddr, 3);
      check("t1_rf_wsel", rf_wsel, 0);
      tick();                                  // ptr -> 1
      idle(); disp_fu = 2'd1; disp_rd_en = 1'b1; disp_rd = 5'd3; settle();
      check("t1_rd3_released", disp_ready, 1);

      // ---- RAW: ALU rd=5 in EXEC, LD_ST reads rs1=5 ----
      idle(); drive(2'd0, 1, 5'd5, 0, 5'd0, 0, 5'd0); tick();
      idle(); issue_ack = 3'b001; tick();
      idle(); drive(2'd1, 1, 5'd6, 1, 5'd5, 0, 5'd0); settle();
      check("t2_ready", disp_ready, 1);
      tick();
      idle(); settle();
      check("t2_blocked", issue_valid, 0);
      wb_valid = 3'b001; settle();
      check("t2_wb_ready", wb_ready, 3'b001);
      check("t2_rf_wen", rf_wen, 1);
      check("t2_rf_waddr", rf_waddr, 5);
      tick();                                  // ptr -> 1
      idle(); settle();
      check("t2_wakeup_issue", issue_valid, 3'b010);
      check("t2_issue_rs1", issue_rs1[9:5], 5);
      check("t2_issue_rd", issue_rd[9:5], 6);
      issue_ack = 3'b010; tick();              // LD_ST rd=6 in EXEC

      // ---- WAW: RST[7] busy blocks a new rd=7 until after its grant ----
      idle(); drive(2'd0, 1, 5'd7, 0, 5'd0, 0, 5'd0); tick();
      idle(); issue_ack = 3'b001; tick();
      idle(); drive(2'd2, 1, 5'd7, 0, 5'd0, 0, 5'd0); settle();
      check("t3_waw_stall_a", disp_ready, 0);
      tick();
      wb_valid = 3'b011; settle();
      check("t3_rr_from1", wb_ready, 3'b010);
      check("t3_waddr6", rf_waddr, 6);
      check("t3_waw_stall_b", disp_ready, 0);
      tick();                                  // ptr -> 2
      wb_valid = 3'b001; settle();
      check("t3_wrap_grant", wb_ready, 3'b001);
      check("t3_waddr7", rf_waddr, 7);
      check("t3_waw_stall_c", disp_ready, 0);
      tick();                                  // ptr -> 1
      wb_valid = '0; settle();
      check("t3_waw_released", disp_ready, 1);
      idle();

      // ---- BRANCH needs a grant but never writes ----
      drive(2'd2, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
      idle(); settle();
      check("t4_br_issue", issue_valid, 3'b100);
      issue_ack = 3'b100; tick();
      idle(); wb_valid = 3'b100; settle();
      check("t4_br_wb_ready", wb_ready, 3'b100);
      check("t4_br_rf_wen", rf_wen, 0);
      check("t4_br_rf_wsel", rf_wsel, 2);
      tick();                                  // ptr -> 0

      // ---- both ALU and LD_ST hold wb_valid from pointer 0 ----
      idle(); drive(2'd0, 1, 5'd8, 0, 5'd0, 0, 5'd0); tick();
      idle(); drive(2'd1, 1, 5'd9, 0, 5'd0, 0, 5'd0); tick();
      idle(); settle();
      check("t5_issue_both", issue_valid, 3'b011);
      issue_ack = 3'b011; tick();
      idle(); wb_valid = 3'b011; settle();
      check("t5_first_alu", wb_ready, 3'b001);
      check("t5_first_waddr", rf_waddr, 8);
      tick();                                  // ptr -> 1
      idle(); wb_valid = 3'b010; settle();
      check("t5_second_ldst", wb_ready, 3'b010);
      check("t5_second_waddr", rf_waddr, 9);
      check("t5_second_wsel", rf_wsel, 1);
      tick();                                  // ptr -> 2
      idle(); drive(2'd0, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
      idle(); drive(2'd2, 0, 5'd0, 0, 5'd0, 0, 5'd0); tick();
      idle(); settle();
      check("t5_issue_alu_br", issue_valid, 3'b101);
      issue_ack = 3'b101; tick();
      idle(); wb_valid = 3'b101; settle();
      check("t5_ptr2_branch_first", wb_ready, 3'b100);
      tick();                                  // ptr -> 0
      idle(); wb_valid = 3'b001; settle();
      check("t5_alu_after", wb_ready, 3'b001);
      tick();                                  // ptr -> 1

      // ---- WAR: BRANCH reads x4 (ready) waiting on x10; LD_ST writes x4 ----
      idle(); drive(2'd0, 1, 5'd10, 0, 5'd0, 0, 5'd0); tick();
      idle(); issue_ack = 3'b001; drive(2'd2, 0, 5'd0, 1, 5'd4, 1, 5'd10); settle();
      check("t6_br_ready", disp_ready, 1);
      tick();
      idle(); drive(2'd1, 1, 5'd4, 0, 5'd0, 0, 5'd0); settle();
      check("t6_ldst_ready", disp_ready, 1);
      tick();
      idle(); settle();
      check("t6_only_ldst_issue", issue_valid, 3'b010);
      issue_ack = 3'b010; tick();
      idle(); wb_valid = 3'b010; settle();
      check("t6_war_hold_a", wb_ready, 3'b000);
      tick();
      settle();
      check("t6_war_hold_b", wb_ready, 3'b000);
      wb_valid = 3'b011; settle();
      check("t6_alu_grant", wb_ready, 3'b001);
      check("t6_alu_waddr", rf_waddr, 10);
      tick();                                  // ptr -> 1
      idle(); wb_valid = 3'b010; settle();
      check("t6_br_woken", issue_valid, 3'b100);
      check("t6_war_hold_c", wb_ready, 3'b000);
      issue_ack = 3'b100; tick();
      idle(); wb_valid = 3'b010; settle();
      check("t6_war_release", wb_ready, 3'b010);
      check("t6_waddr4", rf_waddr, 4);
      check("t6_wen4", rf_wen, 1);
      tick();                                  // ptr -> 2
      idle(); wb_valid = 3'b100; settle();
      check("t6_br_drain", wb_ready, 3'b100);
      tick();                                  // ptr -> 0

      // ---- same-cycle bypass: dispatch reads x11 while its producer is granted ----
      idle(); drive(2'd0, 1, 5'd11, 0, 5'd0, 0, 5'd0); tick();
      idle(); issue_ack = 3'b001; tick();
      idle(); wb_valid = 3'b001; drive(2'd1, 0, 5'd0, 1, 5'd11, 0, 5'd0); settle();
      check("t7_disp_ready", disp_ready, 1);
      check("t7_grant", wb_ready, 3'b001);
      tick();                                  // ptr -> 1
      idle(); settle();
      check("t7_bypass_issue", issue_valid, 3'b010);

      // ---- reset with LD_ST in EXEC ----
      issue_ack = 3'b010; tick();
      idle(); wb_valid = 3'b010; settle();
      check("t8_pre_grant", wb_ready, 3'b010);
      nRST = 1'b0; settle();
      check("t8_rst_wb_ready", wb_ready, 0);
      check("t8_rst_rf_wen", rf_wen, 0);
      check("t8_rst_issue", issue_valid, 0);
      @(posedge CLK); #1;
      nRST = 1'b1; settle();
      check("t8_post_wb_ready", wb_ready, 0);
      wb_valid = '0;
      for (int f = 0; f < 3; f++) begin
         disp_fu = 2'(f); disp_rd_en = 1'b1; disp_rd = 5'd11; settle();
         check($sformatf("t8_ready_fu%0d", f), disp_ready, 1);
      end
      idle(); drive(2'd0, 1, 5'd0, 1, 5'd0, 0, 5'd0); settle();
      check("t8_x0_disp", disp_ready, 1);
      tick();
      idle(); drive(2'd1, 0, 5'd0, 1, 5'd0, 1, 5'd0); settle();
      check("t8_x0_issue", issue_valid, 3'b001);
      tick();
      idle(); settle();
      check("t8_x0_src_issue", issue_valid, 3'b011);
      issue_ack = 3'b011; tick();
      idle(); wb_valid = 3'b001; settle();
      check("t8_x0_grant", wb_ready, 3'b001);
      check("t8_x0_no_wen", rf_wen, 0);
      tick();
      idle(); wb_valid = 3'b010; settle();
      check("t8_ldst_grant", wb_ready, 3'b010);
      tick();
      idle();

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
